exec_unit: RTL and testbench

EXEC_UNIT -- requirements
Module: exec_unit

---
 rtl/exec_unit.sv | 94 +++++++++
 tb/tb_exec_unit.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/exec_unit.sv
// Arithmetic, bitwise and jump-target units in parallel, each result registered: one-cycle latency.
// No enable or handshake: all three units accept new inputs every cycle, and outputs clear asynchronously on reset.
module exec_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       aop,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] o,
  output logic [WIDTH-1:0] os,
  input  logic [1:0]       bop,
  input  logic [WIDTH-1:0] bx,
  input  logic [WIDTH-1:0] by,
  output logic [WIDTH-1:0] boo,
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] val,
  input  logic             as,
  output logic [WIDTH-1:0] pcos
);

  localparam logic [4:0] AOP_RETX   = 5'd0;
  localparam logic [4:0] AOP_RETY   = 5'd1;
  localparam logic [4:0] AOP_ADD    = 5'd2;
  localparam logic [4:0] AOP_SUB    = 5'd3;
  localparam logic [4:0] AOP_CMP    = 5'd4;
  localparam logic [4:0] AOP_LSHIFT = 5'd5;

  logic [WIDTH-1:0] o_d, os_d, boo_d, pcos_d;
  logic [WIDTH-1:0] o_q, os_q, boo_q, pcos_q;
  logic [WIDTH-1:0] sum_w, diff_w, shl_w;

  assign sum_w  = x + y;
  assign diff_w = x - y;
  assign shl_w  = {x[WIDTH-2:0], 1'b0} + y;

  // Status bit1 is zero, bit0 is equal; everything else passes through from s.
  always_comb begin
    o_d  = '0;
    os_d = s;
    case (aop)
      AOP_RETX:   o_d = x;
      AOP_RETY:   o_d = y;
      AOP_ADD: begin
        o_d     = sum_w;
        os_d[1] = (sum_w == '0);
      end
      AOP_SUB: begin
        o_d     = diff_w;
        os_d[1] = (diff_w == '0);
      end
      AOP_CMP: begin
        o_d     = x;
        os_d[0] = (x == y);
      end
      AOP_LSHIFT: o_d = shl_w;
      default:    o_d = '0;
    endcase
  end

  always_comb begin
    boo_d = '0;
    case (bop)
      2'd0:    boo_d = bx & by;
      2'd1:    boo_d = bx | by;
      2'd2:    boo_d = bx ^ by;
      default: boo_d = ~(bx & by);
    endcase
  end

  assign pcos_d = as ? (pc - val) : (pc + val);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_q    <= '0;
      os_q   <= '0;
      boo_q  <= '0;
      pcos_q <= '0;
    end else begin
      o_q    <= o_d;
      os_q   <= os_d;
      boo_q  <= boo_d;
      pcos_q <= pcos_d;
    end
  end

  assign o    = o_q;
  assign os   = os_q;
  assign boo  = boo_q;
  assign pcos = pcos_q;

endmodule

// File: tb/tb_exec_unit.sv
// Directed and random checks of exec_unit against an arithmetic reference model.
module tb_exec_unit;

  localparam int W = 8;
  localparam int M = 256;

  logic         clk;
  logic         rst_n;
  logic [4:0]   aop;
  logic [W-1:0] x, y, s, o, os;
  logic [1:0]   bop;
  logic [W-1:0] bx, by, boo;
  logic [W-1:0] pc, val, pcos;
  logic         as;

  int checks = 0;
  int errors = 0;

  exec_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .aop(aop), .x(x), .y(y), .s(s), .o(o), .os(os),
    .bop(bop), .bx(bx), .by(by), .boo(boo),
    .pc(pc), .val(val), .as(as), .pcos(pcos)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: results from plain integer arithmetic modulo 2^W.
  task automatic model(output logic [W-1:0] eo, output logic [W-1:0] eos,
                       output logic [W-1:0] eboo, output logic [W-1:0] epc);
    int xi, yi, si, r;
    xi = int'(x); yi = int'(y); si = int'(s);
    r = 0;
    eos = s;
    case (int'(aop))
      0: r = xi;
      1: r = yi;
      2: begin r = (xi + yi) % M; eos = W'((si & ~2) | ((r == 0) ? 2 : 0)); end
      3: begin r = (xi - yi + M) % M; eos = W'((si & ~2) | ((r == 0) ? 2 : 0)); end
      4: begin r = xi; eos = W'((si & ~1) | ((xi == yi) ? 1 : 0)); end
      5: r = (2 * xi + yi) % M;
      default: r = 0;
    endcase
    eo = W'(r);
    case (int'(bop))
      0: eboo = bx & by;
      1: eboo = bx | by;
      2: eboo = bx ^ by;
      default: eboo = ~(bx & by);
    endcase
    epc = as ? W'((int'(pc) - int'(val) + M) % M) : W'((int'(pc) + int'(val)) % M);
  endtask

  task automatic drive(input logic [4:0] a, input logic [W-1:0] xa, input logic [W-1:0] ya,
                       input logic [W-1:0] sa, input logic [1:0] b, input logic [W-1:0] bxa,
                       input logic [W-1:0] bya, input logic [W-1:0] pca, input logic [W-1:0] va,
                       input logic asa);
    aop = a; x = xa; y = ya; s = sa; bop = b; bx = bxa; by = bya; pc = pca; val = va; as = asa;
  endtask

  task automatic rand_inputs();
    drive(($urandom_range(0, 3) == 0) ? 5'($urandom_range(6, 31)) : 5'($urandom_range(0, 5)),
          W'($urandom), W'($urandom), W'($urandom), 2'($urandom), W'($urandom), W'($urandom),
          W'($urandom), W'($urandom), 1'($urandom));
    if ($urandom_range(0, 4) == 0) y = x;
  endtask

  // Capture current inputs on the next edge and compare everything against the model.
  task automatic step_check(input string tag);
    logic [W-1:0] eo, eos, eboo, epc;
    model(eo, eos, eboo, epc);
    @(posedge clk);
    #1;
    check({tag, ".o"}, o, eo);
    check({tag, ".os"}, os, eos);
    check({tag, ".boo"}, boo, eboo);
    check({tag, ".pcos"}, pcos, epc);
  endtask

  initial begin
    rst_n = 1'b1;
    drive(5'd2, 8'h11, 8'h22, 8'h00, 2'd1, 8'h0F, 8'hF0, 8'h10, 8'h01, 1'b0);
    @(negedge clk);
    step_check("pre_reset");

    // Asynchronous reset mid-cycle with arbitrary inputs.
    #2 rst_n = 1'b0;
    rand_inputs();
    #1;
    check("rst_async.o", o, 8'h00);
    check("rst_async.os", os, 8'h00);
    check("rst_async.boo", boo, 8'h00);
    check("rst_async.pcos", pcos, 8'h00);
    @(posedge clk);
    #1;
    check("rst_hold.o", o, 8'h00);
    check("rst_hold.pcos", pcos, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    drive(5'd2, 8'h05, 8'h03, 8'h00, 2'd0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    @(posedge clk);
    #1;
    check("rst_first_add", o, 8'h08);

    // Directed vectors with literal expectations.
    @(negedge clk);
    drive(5'd2, 8'hFF, 8'h01, 8'h01, 2'd0, 8'hF0, 8'h3C, 8'hFE, 8'h05, 1'b0);
    @(posedge clk); #1;
    check("add_wrap.o", o, 8'h00);
    check("add_wrap.os", os, 8'h03);
    check("bit_and", boo, 8'h30);
    check("pc_add_wrap", pcos, 8'h03);

    @(negedge clk);
    drive(5'd3, 8'h00, 8'h01, 8'h00, 2'd1, 8'hF0, 8'h3C, 8'h02, 8'h05, 1'b1);
    @(posedge clk); #1;
    check("sub_wrap.o", o, 8'hFF);
    check("sub_wrap.os", os, 8'h00);
    check("bit_or", boo, 8'hFC);
    check("pc_sub_wrap", pcos, 8'hFD);

    @(negedge clk);
    drive(5'd4, 8'h2A, 8'h2A, 8'h02, 2'd2, 8'hF0, 8'h3C, 8'h00, 8'h00, 1'b0);
    @(posedge clk); #1;
    check("cmp_eq.o", o, 8'h2A);
    check("cmp_eq.os", os, 8'h03);
    check("bit_xor", boo, 8'hCC);

    @(negedge clk);
    drive(5'd4, 8'h2A, 8'h2B, 8'h01, 2'd3, 8'hF0, 8'h3C, 8'h00, 8'h00, 1'b0);
    @(posedge clk); #1;
    check("cmp_ne.os", os, 8'h00);
    check("bit_nand", boo, 8'hCF);

    @(negedge clk);
    drive(5'd5, 8'h81, 8'h04, 8'h00, 2'd0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    @(posedge clk); #1;
    check("lshift", o, 8'h06);

    @(negedge clk);
    drive(5'd1, 8'h00, 8'h5C, 8'hA4, 2'd0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    @(posedge clk); #1;
    check("rety.o", o, 8'h5C);
    check("rety.os", os, 8'hA4);

    @(negedge clk);
    drive(5'd7, 8'h12, 8'h34, 8'h55, 2'd0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    @(posedge clk); #1;
    check("aop7.o", o, 8'h00);
    check("aop7.os", os, 8'h55);

    // Random back-to-back vectors against the model.
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      rand_inputs();
      step_check("rand");
    end

    // Reset while a result is held: it must be discarded.
    @(negedge clk);
    drive(5'd0, 8'hA5, 8'h00, 8'hFF, 2'd1, 8'hAA, 8'h55, 8'h40, 8'h01, 1'b0);
    step_check("pre_midrst");
    #2 rst_n = 1'b0;
    #1;
    check("midrst.o", o, 8'h00);
    check("midrst.os", os, 8'h00);
    check("midrst.boo", boo, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    rand_inputs();
    step_check("post_midrst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
